// File: rtl/serial_subtractor.sv
// Bit-serial unsigned subtractor: computes a - b LSB-first over WIDTH cycles.
// Define SERIAL_SUB_SAT_EN to saturate diff to zero on underflow.
module serial_subtractor #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             borrow_out
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;

  state_t           state, next_state;
  logic [WIDTH-1:0] a_reg, b_reg, res_reg, res_next;
  logic [CW-1:0]    cnt;
  logic             brw, d_bit, brw_next, last;

  assign last     = (cnt == LAST);
  assign d_bit    = a_reg[0] ^ b_reg[0] ^ brw;
  assign brw_next = (~a_reg[0] & b_reg[0]) | (~a_reg[0] & brw) | (b_reg[0] & brw);
  // New bit enters at the MSB so the first computed bit ends up in bit 0.
  assign res_next = WIDTH'({d_bit, res_reg} >> 1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    case (state)
      IDLE:  if (start) next_state = SHIFT;
      SHIFT: begin
        busy = 1'b1;
        if (last) next_state = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        next_state = IDLE;
      end
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_reg      <= '0;
      b_reg      <= '0;
      res_reg    <= '0;
      cnt        <= '0;
      brw        <= 1'b0;
      diff       <= '0;
      borrow_out <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            a_reg   <= a;
            b_reg   <= b;
            res_reg <= '0;
            cnt     <= '0;
            brw     <= 1'b0;
          end
        end
        SHIFT: begin
          a_reg   <= a_reg >> 1;
          b_reg   <= b_reg >> 1;
          res_reg <= res_next;
          brw     <= brw_next;
          cnt     <= cnt + 1'b1;
          if (last) begin
            borrow_out <= brw_next;
`ifdef SERIAL_SUB_SAT_EN
            diff <= brw_next ? '0 : res_next;
`else
            diff <= res_next;
`endif
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: directed corner cases plus random
// operands checked against an arithmetic reference model.
module tb_serial_subtractor;

  localparam int W = 8;

  logic         clk, rst_n, start;
  logic [W-1:0] a, b;
  logic         busy, done, borrow_out;
  logic [W-1:0] diff;

  int checks   = 0;
  int failures = 0;

  serial_subtractor #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .busy(busy), .done(done), .diff(diff), .borrow_out(borrow_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [W-1:0] model_diff(input logic [W-1:0] x, input logic [W-1:0] y);
    int r;
    r = int'(x) - int'(y);
    if (r < 0) r += (1 << W);
`ifdef SERIAL_SUB_SAT_EN
    if (x < y) r = 0;
`endif
    return W'(r);
  endfunction

  task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic apply_stimulus(input logic [W-1:0] x, input logic [W-1:0] y);
    start = 1'b1;
    a     = x;
    b     = y;
  endtask

  // Starts at a negedge with the FSM idle; returns at the negedge after done.
  task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y);
    apply_stimulus(x, y);
    @(negedge clk);
    start = 1'b0;
    a = W'($urandom);
    b = W'($urandom);
    check_output("busy_after_accept", busy, 1);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      check_output("done_timing", done, (k == W));
      if (k == W) begin
        check_output("diff", diff, model_diff(x, y));
        check_output("borrow_out", borrow_out, (x < y));
      end
    end
    @(negedge clk);
    check_output("idle_busy", busy, 0);
    check_output("idle_done", done, 0);
    check_output("diff_hold", diff, model_diff(x, y));
  endtask

  initial begin
    logic [W-1:0] p, q, r, s;
    rst_n = 1'b0;
    start = 1'b0;
    a = '0;
    b = '0;
    #2;
    check_output("rst_busy", busy, 0);
    check_output("rst_done", done, 0);
    check_output("rst_diff", diff, 0);
    check_output("rst_borrow", borrow_out, 0);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check_output("no_start_on_release", busy, 0);

    run_op(8'h5A, 8'h23);
    run_op(8'h10, 8'h20);
    run_op(8'hFF, 8'hFF);
    run_op(8'h00, 8'h01);
    run_op(8'h00, 8'hFF);
    run_op(8'hFF, 8'h00);
    for (int i = 0; i < 20; i++) run_op(W'($urandom), W'($urandom));

    // start held high with changing operands during the whole operation
    p = W'($urandom);
    q = W'($urandom);
    r = W'($urandom);
    s = W'($urandom);
    apply_stimulus(p, q);
    @(negedge clk);
    for (int k = 1; k <= W + 1; k++) begin
      a = W'($urandom);
      b = W'($urandom);
      @(negedge clk);
      check_output("hold_done", done, (k == W));
      check_output("hold_busy", busy, (k <= W));
      if (k == W) begin
        check_output("hold_diff", diff, model_diff(p, q));
        check_output("hold_borrow", borrow_out, (p < q));
      end
    end
    a = r;
    b = s;
    @(negedge clk);
    start = 1'b0;
    check_output("hold_restart_busy", busy, 1);
    for (int k = 1; k <= W; k++) begin
      @(negedge clk);
      check_output("hold2_done", done, (k == W));
      if (k == W) check_output("hold2_diff", diff, model_diff(r, s));
    end
    @(negedge clk);

    // reset in the middle of an operation
    run_op(8'h5A, 8'h23);
    apply_stimulus(8'hC3, 8'h3C);
    @(negedge clk);
    start = 1'b0;
    repeat (3) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check_output("midrst_busy", busy, 0);
    check_output("midrst_done", done, 0);
    check_output("midrst_diff", diff, 0);
    check_output("midrst_borrow", borrow_out, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < W + 2; k++) begin
      @(negedge clk);
      check_output("postrst_done", done, 0);
      check_output("postrst_busy", busy, 0);
    end
    run_op(8'h09, 8'h04);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/serial_subtractor.md
SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

Interface
REQ-001 Parameter: WIDTH, default 8, operand and result width in bits (legal range 2..32).
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 rst_n  input  1  asynchronous active-low reset.
REQ-004 start  input  1  request to begin a subtraction; sampled on rising edge of clk.
REQ-005 a  input  WIDTH  minuend; captured when start is accepted.
REQ-006 b  input  WIDTH  subtrahend; captured when start is accepted.
REQ-007 busy  output  1  high while an operation is in progress (states SHIFT and DONE).
REQ-008 done  output  1  one-cycle pulse marking diff/borrow_out valid.
REQ-009 diff  output  WIDTH  result of a - b.
REQ-010 borrow_out  output  1  final borrow; 1 when a < b (unsigned).

Function
REQ-011 The FSM SHALL have three states: IDLE, SHIFT, DONE.
REQ-012 In IDLE with start=1 at edge E0, the block SHALL load a and b into shift registers, clear the bit counter and the borrow flop, and enter SHIFT.
REQ-013 Each SHIFT edge SHALL compute one bit LSB-first: d = a0 ^ b0 ^ brw; brw_next = (~a0 & b0) | (~a0 & brw) | (b0 & brw).
REQ-014 Each SHIFT edge SHALL shift d into the result register MSB-first so that after WIDTH steps bit 0 holds the first computed bit.
REQ-015 After exactly WIDTH SHIFT edges (E1..E_WIDTH), the FSM SHALL enter DONE with diff and borrow_out updated on edge E_WIDTH.
REQ-016 done SHALL be 1 only while in DONE, for exactly one cycle; the next edge SHALL return the FSM to IDLE.
REQ-017 Latency: done SHALL be high in the cycle following edge E_WIDTH, i.e. WIDTH cycles after the accepting edge.
REQ-018 start SHALL be ignored in SHIFT and DONE; operands SHALL not change mid-operation.
REQ-019 diff and borrow_out SHALL hold their last values in IDLE until the next completion overwrites them.
REQ-020 The bit counter SHALL be sized ceil(log2(WIDTH+1)) bits and SHALL not wrap within an operation.
REQ-021 Arithmetic SHALL be unsigned modulo 2^WIDTH; borrow_out SHALL equal (a < b).

Reset
REQ-022 rst_n=0 SHALL immediately force state=IDLE, busy=0, done=0, diff=0, borrow_out=0, counter=0, borrow flop=0, operand registers=0.
REQ-023 Reset asserted mid-operation SHALL abort the operation with no done pulse; the first start after release SHALL be accepted normally.
REQ-024 Reset deassertion SHALL not by itself start an operation.

Configuration
REQ-025 Macro SERIAL_SUB_SAT_EN SHALL select underflow saturation.
REQ-026 With SERIAL_SUB_SAT_EN defined: when the final borrow is 1, diff SHALL be forced to 0 at E_WIDTH; borrow_out still 1.
REQ-027 Without SERIAL_SUB_SAT_EN: diff SHALL be the two's-complement wrapped result; no saturation logic SHALL be present.

Verification
REQ-028 WIDTH=8, a=0x5A, b=0x23, start 1 cycle -> busy high from E0, done pulse 8 cycles after E0, diff=0x37, borrow_out=0.
REQ-029 a=0x10, b=0x20 -> borrow_out=1; diff=0xF0 without macro, diff=0x00 with SERIAL_SUB_SAT_EN.
REQ-030 a=0xFF, b=0xFF -> diff=0x00, borrow_out=0; a=0x00, b=0x01 -> diff=0xFF (0x00 saturated), borrow_out=1.
REQ-031 start held high with new operands throughout SHIFT and DONE -> first result unaffected, exactly one done; new operation begins only on the first IDLE edge.
REQ-032 rst_n pulsed low at cycle 4 of an operation -> outputs 0 immediately, no done; subsequent 0x09-0x04 -> diff=0x05, borrow_out=0.
